// File: rtl/fir_2.sv
// fir_2: N-stage CIC decimating low-pass filter.
//
// Integrators run every clock. Every R clocks the integrator output is
// decimated and passed through N comb stages with differential delay M.
// All arithmetic is modular OW-bit two's complement. Wrap-around inside the
// integrators is expected, and the combs cancel it.
//
// Parameters:
//   R  - decimation ratio (power of two)
//   N  - number of integrator stages and comb stages
//   M  - comb differential delay, in decimated samples
//   IW - input width
//   OW - output/internal width, IW + N*log2(R*M)
//
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   x       - signed input sample, one per clock
//   y       - signed decimated output, updates once every R clocks
//   y_valid - one-cycle strobe in the cycle a new y first appears
//             (only when FIR_2_VALID_EN is defined)
//
// Build option: define FIR_2_VALID_EN to add the y_valid port.
module fir_2 #(
  parameter int unsigned R  = 32,
  parameter int unsigned N  = 3,
  parameter int unsigned M  = 2,
  parameter int unsigned IW = 8,
  parameter int unsigned OW = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [IW-1:0] x,
  output logic signed [OW-1:0] y
`ifdef FIR_2_VALID_EN
  ,
  output logic                 y_valid
`endif
);

  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;

  logic [CW-1:0]        cnt;
  logic                 strobe;
  logic signed [OW-1:0] x_ext;
  logic signed [OW-1:0] integ    [N];
  logic signed [OW-1:0] dly      [N][M];
  logic signed [OW-1:0] stage_in [N];
  logic signed [OW-1:0] comb_out;

  assign strobe = (cnt == CW'(R - 1));
  assign x_ext  = {{(OW - IW){x[IW-1]}}, x};

  // Decimation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Integrator chain; each stage adds the previous stage's registered value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
      end
    end else begin
      integ[0] <= integ[0] + x_ext;
      for (int k = 1; k < N; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  // Comb chain: stage k subtracts its own input from M strobes ago.
  // stage_in[k] is what stage k's delay line captures on the strobe.
  always_comb begin
    comb_out = integ[N-1];
    for (int k = 0; k < N; k++) begin
      stage_in[k] = comb_out;
      comb_out    = comb_out - dly[k][M-1];
    end
  end

  // Comb delay lines and output register advance only on strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < M; i++) begin
          dly[k][i] <= '0;
        end
      end
      y <= '0;
    end else if (strobe) begin
      for (int k = 0; k < N; k++) begin
        dly[k][0] <= stage_in[k];
        for (int i = 1; i < M; i++) begin
          dly[k][i] <= dly[k][i-1];
        end
      end
      y <= comb_out;
    end
  end

`ifdef FIR_2_VALID_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid <= 1'b0;
    end else begin
      y_valid <= strobe;
    end
  end
`endif

endmodule

// File: tb/tb_fir_2.sv
// Self-checking bench for fir_2 (default parameters).
// The reference is a direct-form FIR that uses the CIC impulse response
// (a 64-tap boxcar convolved with itself three times, 190 taps). The first
// strobe after reset comes on edge 32, and it sees integrator state through
// edge 31. So the output at edge t equals sum_j h[j] * x[t-3-j]. Input x[s]
// is the sample taken on edge s after reset release.
`timescale 1ns/1ps
module tb_fir_2;

  localparam int unsigned R  = 32;
  localparam int unsigned N  = 3;
  localparam int unsigned M  = 2;
  localparam int unsigned IW = 8;
  localparam int unsigned OW = 26;
  localparam int HLEN = 190;
  localparam int MAXT = 2048;

  localparam longint DC_POS = 33292288;   // 127 * 2^18
  localparam longint DC_NEG = -33554432;  // -128 * 2^18

  logic                 clk   = 1'b0;
  logic                 reset = 1'b1;
  logic signed [IW-1:0] x     = '0;
  logic signed [OW-1:0] y;
`ifdef FIR_2_VALID_EN
  logic                 y_valid;
`endif

  fir_2 #(
    .R (R),
    .N (N),
    .M (M),
    .IW(IW),
    .OW(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .y    (y)
`ifdef FIR_2_VALID_EN
    ,
    .y_valid(y_valid)
`endif
  );

  always #5 clk = ~clk;

  int                   n_checks = 0;
  int                   n_fail   = 0;
  longint               h  [HLEN];
  longint               h2 [127];
  logic signed [IW-1:0] xs [MAXT];
  int                   t;
  longint               exp_y;

  task automatic check_eq(input string tag, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, want, t);
    end
  endtask

  function automatic longint model(input int tt);
    longint acc = 0;
    for (int j = 0; j < HLEN; j++) begin
      int s = tt - 3 - j;
      if (s >= 1) acc += h[j] * longint'(xs[s]);
    end
    return acc;
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    x     = '0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    t     = 0;
    exp_y = 0;
    check_eq("reset_y", longint'(y), 0);
`ifdef FIR_2_VALID_EN
    check_eq("reset_valid", longint'(y_valid), 0);
`endif
  endtask

  // Apply one sample, clock it in, then check y and y_valid against the model.
  task automatic step(input logic signed [IW-1:0] v, input string tag);
    x = v;
    @(posedge clk);
    #1;
    if (t < MAXT - 1) t++;
    xs[t] = v;
    if (t % R == 0) exp_y = model(t);
    check_eq(tag, longint'(y), exp_y);
`ifdef FIR_2_VALID_EN
    check_eq({tag, "_valid"}, longint'(y_valid), longint'(t % R == 0));
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint prev_y;
    longint imp_sum;
    int     imp_nz;
    int     imp_neg;
    real    pi;
    int     v;

    // Reference impulse response: 64-tap boxcar convolved three times
    for (int i = 0; i < 127; i++) h2[i] = 0;
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++) h2[a+b]++;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    for (int i = 0; i < 127; i++)
      for (int c = 0; c < 64; c++) h[i+c] += h2[i];

    // Zero input
    do_reset(3);
    repeat (1000) step(8'sd0, "zero");

    // DC step, positive
    do_reset(2);
    prev_y = 0;
    for (int k = 0; k < 320; k++) begin
      step(8'sd127, "dc");
      if (t % R == 0) begin
        check_eq("dc_mono", longint'(longint'(y) >= prev_y), 1);
        if (t / R >= 7) check_eq("dc_final", longint'(y), DC_POS);
        prev_y = longint'(y);
      end
    end

    // Negative full scale
    do_reset(2);
    for (int k = 0; k < 320; k++) begin
      step(-8'sd128, "neg");
      if (t % R == 0 && t / R >= 7) check_eq("neg_final", longint'(y), DC_NEG);
    end

    // Impulse
    do_reset(2);
    imp_sum = 0;
    imp_nz  = 0;
    imp_neg = 0;
    step(8'sd127, "imp");
    for (int k = 0; k < 400; k++) begin
      step(8'sd0, "imp");
      if (t % R == 0 && y != 0) begin
        imp_nz++;
        imp_sum += longint'(y);
        if (y < 0) imp_neg++;
      end
    end
    check_eq("imp_count_le7", longint'(imp_nz <= 7), 1);
    check_eq("imp_negatives", imp_neg, 0);
    // Decimation keeps one polyphase branch of h, which sums to (R*M)^N / R.
    check_eq("imp_sum", imp_sum, 127 * 8192);
    check_eq("imp_tail", longint'(y), 0);

    // Reset in the middle of a DC step, then re-settle
    do_reset(2);
    repeat (100) step(8'sd127, "mid_pre");
    check_eq("mid_pre_nonzero", longint'(y != 0), 1);
    do_reset(1);
    for (int k = 0; k < 320; k++) begin
      step(8'sd127, "mid_post");
      if (t == R - 1) check_eq("mid_hold", longint'(y), 0);
      if (t % R == 0 && t / R >= 7) check_eq("mid_final", longint'(y), DC_POS);
    end

    // Two tones: the low tone has a 1024-clock period, the high tone an 8-clock period
    do_reset(2);
    pi = 3.14159265358979;
    for (int k = 1; k <= 1100; k++) begin
      v = int'(60.0 * $sin(2.0 * pi * k / 1024.0) + 60.0 * $sin(2.0 * pi * k / 8.0));
      step(IW'(v), "tones");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
